// File: rtl/spi_cmd_pkg.sv
// Shared command definitions for the SPI framebuffer protocol: opcode bytes
// and the parser state encoding used by spi_frame_writer.
package spi_cmd_pkg;

    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_FILL     = 8'h03;
    localparam logic [7:0] OP_SWAP     = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN,
        ST_DATA,
        ST_FILL_VAL,
        ST_FILLING
    } parser_state_t;

endpackage

// File: rtl/spi_frame_writer.sv
// Decodes the byte stream from SPIReader into framebuffer RAM writes.
// Supports SET_ADDR, burst WRITE with auto-incrementing pointer, whole-buffer
// FILL and buffer SWAP; unknown opcodes and bytes arriving during a fill set
// a sticky error flag.
import spi_cmd_pkg::*;

module spi_frame_writer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data,
    input  logic              received,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              swap,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    parser_state_t     state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [7:0]        addr_hi, addr_hi_n;
    logic [8:0]        byte_cnt, byte_cnt_n;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_data_n;
    logic              mem_we_n;
    logic              swap_n;
    logic              busy_n;
    logic              err_n;
    logic [15:0]       addr_word;

    // Full 16-bit address from the SET_ADDR payload; truncated to ADDR_W on load
    assign addr_word = {addr_hi, data};

    // State, pointer, counters and all outputs registered here; reset aborts any packet or fill
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            addr_hi  <= '0;
            byte_cnt <= '0;
            fill_cnt <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            swap     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            addr_hi  <= addr_hi_n;
            byte_cnt <= byte_cnt_n;
            fill_cnt <= fill_cnt_n;
            mem_addr <= mem_addr_n;
            mem_data <= mem_data_n;
            mem_we   <= mem_we_n;
            swap     <= swap_n;
            busy     <= busy_n;
            err      <= err_n;
        end
    end

    // Next-state and next-output logic; every state except FILLING waits for a received strobe
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        addr_hi_n  = addr_hi;
        byte_cnt_n = byte_cnt;
        fill_cnt_n = fill_cnt;
        mem_addr_n = mem_addr;
        mem_data_n = mem_data;
        mem_we_n   = 1'b0;
        swap_n     = 1'b0;
        busy_n     = busy;
        err_n      = err;

        case (state)
            ST_IDLE: begin
                if (received) begin
                    case (data)
                        OP_SET_ADDR: state_n = ST_ADDR_HI;
                        OP_WRITE:    state_n = ST_LEN;
                        OP_FILL:     state_n = ST_FILL_VAL;
                        OP_SWAP:     swap_n  = 1'b1;
                        default:     err_n   = 1'b1;
                    endcase
                end
            end

            ST_ADDR_HI: begin
                if (received) begin
                    addr_hi_n = data;
                    state_n   = ST_ADDR_LO;
                end
            end

            ST_ADDR_LO: begin
                if (received) begin
                    ptr_n   = ADDR_W'(addr_word);
                    state_n = ST_IDLE;
                end
            end

            ST_LEN: begin
                if (received) begin
                    byte_cnt_n = (data == 8'd0) ? 9'd256 : {1'b0, data};
                    state_n    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (received) begin
                    mem_we_n   = 1'b1;
                    mem_addr_n = ptr;
                    mem_data_n = data;
                    ptr_n      = ptr + ADDR_W'(1);
                    byte_cnt_n = byte_cnt - 9'd1;
                    if (byte_cnt == 9'd1) begin
                        state_n = ST_IDLE;
                    end
                end
            end

            ST_FILL_VAL: begin
                if (received) begin
                    state_n    = ST_FILLING;
                    busy_n     = 1'b1;
                    mem_we_n   = 1'b1;
                    mem_addr_n = '0;
                    mem_data_n = data;
                    fill_cnt_n = '0;
                end
            end

            ST_FILLING: begin
                if (received) begin
                    err_n = 1'b1;
                end
                if (fill_cnt == ADDR_LAST) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end else begin
                    fill_cnt_n = fill_cnt + ADDR_W'(1);
                    mem_addr_n = fill_cnt + ADDR_W'(1);
                    mem_we_n   = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_frame_writer.sv
// Directed-plus-random bench for spi_frame_writer at ADDR_W=4. Expected writes
// come from a simple pointer model: address = ({hi,lo} + index) mod 16.
import spi_cmd_pkg::*;

module tb_spi_frame_writer;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        data = 8'h00;
    logic              received = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              swap;
    logic              busy;
    logic              err;

    int         n_checks  = 0;
    int         n_pass    = 0;
    int         model_ptr = 0;
    logic       model_err = 1'b0;
    logic [7:0] payload[$];

    spi_frame_writer #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .received (received),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .swap     (swap),
        .busy     (busy),
        .err      (err)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // One-cycle byte strobe; returns #1 after the consuming edge
    task automatic applyStimulus(input logic [7:0] b);
        data     = b;
        received = 1'b1;
        @(posedge clk);
        #1;
        received = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".we"},   32'(mem_we), 32'd0);
        checkOutput({tag, ".swap"}, 32'(swap),   32'd0);
        checkOutput({tag, ".busy"}, 32'(busy),   32'd0);
        checkOutput({tag, ".err"},  32'(err),    32'(model_err));
    endtask

    task automatic checkWrite(input string tag, input int exp_addr, input logic [7:0] exp_data);
        checkOutput({tag, ".we"},   32'(mem_we),   32'd1);
        checkOutput({tag, ".addr"}, 32'(mem_addr), 32'(exp_addr));
        checkOutput({tag, ".data"}, 32'(mem_data), 32'(exp_data));
        checkOutput({tag, ".swap"}, 32'(swap),     32'd0);
        checkOutput({tag, ".err"},  32'(err),      32'(model_err));
    endtask

    task automatic doReset();
        rst = 1'b0;
        idleCycle();
        rst = 1'b1;
        model_ptr = 0;
        model_err = 1'b0;
        checkOutput("rst.addr", 32'(mem_addr), 32'd0);
        checkOutput("rst.data", 32'(mem_data), 32'd0);
        checkOutput("rst.we",   32'(mem_we),   32'd0);
        checkOutput("rst.swap", 32'(swap),     32'd0);
        checkOutput("rst.busy", 32'(busy),     32'd0);
        checkOutput("rst.err",  32'(err),      32'd0);
    endtask

    task automatic sendSetAddr(input logic [7:0] hi, input logic [7:0] lo);
        applyStimulus(OP_SET_ADDR);
        checkIdle("setaddr.op");
        applyStimulus(hi);
        checkIdle("setaddr.hi");
        applyStimulus(lo);
        checkIdle("setaddr.lo");
        model_ptr = (int'(hi) * 256 + int'(lo)) % DEPTH;
    endtask

    // Sends WRITE with the current payload queue; length 256 goes out as 0
    task automatic writeBurst(input string tag);
        applyStimulus(OP_WRITE);
        checkIdle({tag, ".op"});
        applyStimulus(8'(payload.size()));
        checkIdle({tag, ".len"});
        foreach (payload[i]) begin
            applyStimulus(payload[i]);
            checkWrite(tag, model_ptr, payload[i]);
            model_ptr = (model_ptr + 1) % DEPTH;
        end
    endtask

    task automatic randomPayload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    // FILL with an optional intruding strobe during fill cycle 'intrude' (1..DEPTH, 0 = none)
    task automatic fillAndCheck(input logic [7:0] value, input int intrude, input logic [7:0] junk);
        applyStimulus(OP_FILL);
        checkIdle("fill.op");
        applyStimulus(value);
        for (int c = 1; c <= DEPTH; c++) begin
            checkOutput("fill.busy", 32'(busy),     32'd1);
            checkOutput("fill.we",   32'(mem_we),   32'd1);
            checkOutput("fill.addr", 32'(mem_addr), 32'(c - 1));
            checkOutput("fill.data", 32'(mem_data), 32'(value));
            checkOutput("fill.swap", 32'(swap),     32'd0);
            checkOutput("fill.err",  32'(err),      32'(model_err));
            if (c == intrude) begin
                applyStimulus(junk);
                model_err = 1'b1;
            end else begin
                idleCycle();
            end
        end
        checkIdle("fill.done");
    endtask

    initial begin
        logic [7:0] v;

        doReset();

        // Burst write from the worked example
        sendSetAddr(8'h00, 8'h03);
        payload = '{8'hAA, 8'hBB, 8'hCC};
        writeBurst("burst");

        // Random bursts from random start addresses
        repeat (4) begin
            sendSetAddr(8'($urandom), 8'($urandom));
            randomPayload($urandom_range(1, 20));
            writeBurst("rburst");
        end

        // Pointer wrap with a truncated SET_ADDR
        sendSetAddr(8'h12, 8'h0F);
        payload = '{8'h11, 8'h22};
        writeBurst("wrap");
        checkOutput("wrap.ptr", 32'(model_ptr), 32'd1);

        // Fill with a dropped strobe in fill cycle 5; pointer must survive
        fillAndCheck(8'h5A, 5, 8'($urandom));
        randomPayload(1);
        writeBurst("postfill");

        // Strobe in the last fill cycle is dropped, the next cycle accepts an opcode
        v = 8'($urandom);
        fillAndCheck(v, DEPTH, OP_SWAP);
        applyStimulus(OP_SWAP);
        checkOutput("fillend.swap", 32'(swap), 32'd1);
        idleCycle();
        checkOutput("fillend.swap_off", 32'(swap), 32'd0);

        doReset();

        // Swap pulse, bad opcodes, swap still works
        applyStimulus(OP_SWAP);
        checkOutput("swap.pulse", 32'(swap), 32'd1);
        checkOutput("swap.we",    32'(mem_we), 32'd0);
        checkOutput("swap.err",   32'(err), 32'd0);
        idleCycle();
        checkOutput("swap.off", 32'(swap), 32'd0);
        applyStimulus(8'h7E);
        model_err = 1'b1;
        checkIdle("badop");
        applyStimulus(8'($urandom_range(5, 255)));
        checkIdle("badop.rand");
        applyStimulus(OP_SWAP);
        checkOutput("badop.swap", 32'(swap), 32'd1);

        // Length 0 means 256 back-to-back data bytes, then back in IDLE
        sendSetAddr(8'($urandom), 8'($urandom));
        randomPayload(256);
        writeBurst("len0");
        applyStimulus(OP_SWAP);
        checkOutput("len0.idle_swap", 32'(swap), 32'd1);
        checkOutput("len0.idle_we",   32'(mem_we), 32'd0);

        // Reset in the middle of a WRITE packet
        sendSetAddr(8'h00, 8'($urandom_range(1, 15)));
        applyStimulus(OP_WRITE);
        applyStimulus(8'h04);
        applyStimulus(8'h01);
        checkWrite("midpkt", model_ptr, 8'h01);
        doReset();
        applyStimulus(OP_SWAP);
        checkOutput("midpkt.swap", 32'(swap), 32'd1);
        randomPayload(1);
        writeBurst("midpkt.ptr0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_writer.md
# spi_frame_writer

Packet decoder that sits directly downstream of `SPIReader`: it consumes the received byte stream (`data` + `received` strobe) and turns it into write cycles on the display framebuffer RAM port. It parses a small opcode protocol (set address, burst write, fill, swap), auto-increments the write pointer, and flags protocol errors. Output drives a single-port synchronous RAM and the display's buffer-swap logic.

## Interface
- `ADDR_W`, 10, framebuffer address width; memory depth is 2^ADDR_W bytes.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-low (acts on `clk` rising edge while 0).
- `data`  in  8  byte from `SPIReader`; valid only when `received`=1.
- `received`  in  1  one-`clk` strobe per complete byte, synchronous to `clk`.
- `mem_addr`  out  ADDR_W  RAM write address.
- `mem_data`  out  8  RAM write data.
- `mem_we`  out  1  RAM write enable, one cycle per write.
- `swap`  out  1  one-cycle pulse requesting a front/back buffer swap.
- `busy`  out  1  high while a FILL is in progress; incoming bytes are dropped.
- `err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Opcodes: 0x01 SET_ADDR (2 bytes: hi, lo); 0x02 WRITE (length byte N, then N data bytes; N=0 means 256); 0x03 FILL (1 value byte); 0x04 SWAP (no payload). Any other opcode: ignored, `err` set, parser remains in IDLE.
- States: IDLE -> (0x01) ADDR_HI -> ADDR_LO -> IDLE; IDLE -> (0x02) LEN -> DATA -> IDLE after N bytes; IDLE -> (0x03) FILL_VAL -> FILLING -> IDLE; IDLE -> (0x04) IDLE with `swap` pulse.
- Transitions other than FILLING advance only on a `received` strobe.
- Write pointer `ptr` (ADDR_W bits): SET_ADDR loads `{hi,lo}` truncated to the low ADDR_W bits. Each DATA byte is written at `ptr`, then `ptr` increments modulo 2^ADDR_W (wraps from max to 0).
- FILL writes the value to every address 0..2^ADDR_W-1 using an internal counter. `ptr` is unchanged by FILL.
- A `received` strobe while FILLING: byte dropped, `err` set, fill continues unaffected.
- A WRITE spans across a `ptr` wrap without error.

## Timing
- Reset values: `mem_addr`=0, `mem_data`=0, `mem_we`=0, `swap`=0, `busy`=0, `err`=0, `ptr`=0, state IDLE.
- Reset mid-packet or mid-fill aborts immediately. The next byte after reset is treated as an opcode.
- All outputs are registered. A DATA byte strobed in cycle t produces `mem_we`=1 with `mem_addr`=`ptr` and `mem_data`=byte in cycle t+1.
- The `swap` pulse appears in cycle t+1 after the 0x04 strobe in cycle t, and lasts exactly one cycle.
- FILL: value strobed in cycle t. `busy` and `mem_we` are high from t+1 through t+2^ADDR_W, with `mem_addr`=0,1,…,2^ADDR_W-1 on consecutive cycles. `busy`=0 and state IDLE from t+2^ADDR_W+1.
- A strobe arriving in the last FILLING cycle is dropped. A strobe in the first cycle with `busy`=0 is accepted as an opcode.
- `err` rises in the cycle after the offending strobe.
- Back-to-back strobes on consecutive cycles are accepted in every non-FILLING state; throughput is one byte per clock.

## Structure
- Shared package `spi_cmd_pkg`: opcode constants (`OP_SET_ADDR`, `OP_WRITE`, `OP_FILL`, `OP_SWAP`) and the parser state enum. `SPIReader`-side tooling and the bench import the same constants.
- Single module; no sub-module. The fill counter, byte counter and `ptr` are inline registers.

## Test plan
Benches use ADDR_W=4 unless stated.
- **Burst write:** strobe 0x01,0x00,0x03, then 0x02,0x03,0xAA,0xBB,0xCC -> writes (3,0xAA),(4,0xBB),(5,0xCC). Each write is one cycle after its strobe; `err`=0.
- **Wrap:** SET_ADDR 0x12,0x0F (truncates to 0xF), WRITE N=2, 0x11,0x22 -> writes (15,0x11),(0,0x22).
- **Fill with intrusion:** FILL 0x5A -> 16 consecutive writes addr 0..15 value 0x5A, with `busy` high exactly 16 cycles. A strobe in fill cycle 5 is dropped, and `err`=1 from the next cycle onward. `ptr` is unchanged afterwards.
- **Swap and bad opcode:** 0x04 -> single-cycle `swap`. 0x7E -> no write, `err`=1. A following 0x04 still pulses `swap`.
- **Length 0 and back-to-back:** WRITE N=0 with 256 data bytes on consecutive clocks (ADDR_W=10, ptr=0) -> 256 writes at addresses 0..255, then IDLE.
- **Reset mid-packet:** `rst`=0 for one cycle after 0x02,0x04,0x01 -> all outputs at reset values. The next 0x04 pulses `swap` (treated as an opcode).
